imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction-memory path; fetch is the reader. Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes each word into instruction memory through its write port, and holds the core stalled until a complete program has loaded. Sits between the host/UART byte receiver and the instruction memory write port; drives the fetch stall input.

Parameters:
ADDR_WIDTH, 5, word-address width of instruction memory; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, memory word width; only 32 is supported

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a load; ignored unless state is IDLE or DONE
rx_data  input  8  stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  one-cycle write strobe to instruction memory
imem_addr  output  ADDR_WIDTH  word index written; fetch byte address PC maps to PC[ADDR_WIDTH+1:2]
imem_wdata  output  32  assembled word
busy  output  1  high in HDR0, HDR1, DATA, WRITE, CHK
done  output  1  load finished, success or error; held until next start or reset
err  output  1  load failed; held until next start or reset
core_hold  output  1  stall/hold request to the core; high until a successful load
words_loaded  output  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, core_hold=1, words_loaded=0. Internal byte index, word count and checksum are cleared.
- Handshake: a byte transfers on a rising edge where rx_valid && rx_ready. rx_ready=1 only in HDR0, HDR1, DATA and CHK. rx_data may change only after a transfer.
- Frame format: N_lo, N_hi, then 4*N data bytes, little-endian per word (first byte is bits [7:0]).
- IDLE: waits for start, then goes to HDR0.
- DONE: start goes to HDR0 and clears done, err, words_loaded and imem_addr. core_hold is set to 1.
- HDR0: latches N[7:0], then goes to HDR1.
- HDR1: latches N[15:8] and decides the next state:
  - N=0 goes to DONE with no write; err=0, core_hold=0.
  - N > 2**ADDR_WIDTH goes to DONE with err=1; core_hold stays 1 and no write occurs.
  - Otherwise goes to DATA.
- DATA: shifts each accepted byte into a 32-bit assembly register. On the 4th byte it latches imem_wdata and goes to WRITE.
- WRITE: lasts exactly 1 cycle with rx_ready=0 and imem_we=1; imem_addr and imem_wdata are stable.
  - Latency: 4th byte accepted at edge k, imem_we high during the cycle after edge k.
  - On exit: imem_addr++, words_loaded++.
  - If words_loaded reaches N, goes to CHK (feature on) or DONE (feature off). Otherwise goes back to DATA.
- Entering DONE without error: done=1, core_hold=0 on the same edge.
- Address never wraps: the N bound guarantees the last write address is N-1 ≤ 2**ADDR_WIDTH-1.
- start while busy is ignored. rx_valid in IDLE/DONE is ignored; rx_ready stays 0.
- rst at any point, including mid-frame or during WRITE, returns all outputs to reset values on that edge. Partially written memory contents are left as-is, and core_hold returns to 1.
- imem_we is never high in any state other than WRITE.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of all data bytes is cleared on start.
  - After the last WRITE the loader enters CHK and accepts one trailing byte.
  - Match goes to DONE with err=0, core_hold=0.
  - Mismatch goes to DONE with err=1, core_hold stays 1.
  - When N=0 the CHK state is skipped.
- Undefined: no CHK state and no trailing byte. DONE follows the last WRITE directly, and err is raised only by the N-bound check.

Test Plan:
1. Reset, start, stream 02 00 | 13 00 00 00 | 93 00 10 00 with rx_valid held high:
   - imem_we pulses twice: addr 0 data 0x00000013, addr 1 data 0x00100093.
   - Then done=1, err=0, core_hold=0, words_loaded=2.
2. Same frame with rx_valid toggling 1,0,1,0:
   - Identical writes; no byte is lost or duplicated.
   - rx_ready=0 in every WRITE cycle.
3. Frame header 21 00 (N=33, ADDR_WIDTH=5):
   - done=1, err=1, core_hold=1.
   - imem_we never asserts; remaining bytes are not accepted.
4. Header 00 00:
   - done=1, err=0, core_hold=0, no write.
5. Assert rst after the 6th byte of test 1, then run a fresh start with 01 00 | EF BE AD DE:
   - All outputs reset; core_hold=1.
   - Then a single write, addr 0 data 0xDEADBEEF, and done=1.
6. With IMEM_LOADER_CHECKSUM_EN defined, test 1 frame:
   - Trailing byte 0x90 (13^93^10) gives err=0, core_hold=0.
   - Trailing byte 0x00 gives err=1, core_hold=1, with both writes still performed.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed little-endian byte stream and writes 32-bit words into imem.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  core_hold,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [2:0]            state_dbg
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready is
  // registered and only high in HDR0/HDR1/DATA/CHK, so the sender holds rx_data until then.

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state;
  logic [15:0] n_len;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        xfer;
  logic [15:0] n_hdr;
  logic [15:0] wl_next;
  logic        last_word;

  assign state_dbg = state;
  assign xfer      = rx_valid && rx_ready;
  assign n_hdr     = {rx_data, n_len[7:0]};
  assign wl_next   = 16'(words_loaded) + 16'd1;
  assign last_word = (wl_next == n_len);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("imem_loader supports DATA_WIDTH == 32 only");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      core_hold    <= 1'b1;
      words_loaded <= '0;
      n_len        <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_HDR0;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            core_hold    <= 1'b1;
            words_loaded <= '0;
            imem_addr    <= '0;
            byte_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end

        S_HDR0: begin
          if (xfer) begin
            n_len[7:0] <= rx_data;
            state      <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (xfer) begin
            n_len[15:8] <= rx_data;
            if (n_hdr == 16'd0) begin
              // Empty program: nothing to write, the core may run.
              state     <= S_DONE;
              rx_ready  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              err       <= 1'b0;
              core_hold <= 1'b0;
            end else if ({1'b0, n_hdr} > DEPTH) begin
              state    <= S_DONE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              err      <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            // Bytes enter at the top so the first byte ends up in bits [7:0].
            asm_q    <= {rx_data, asm_q[23:8]};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              imem_wdata <= {rx_data, asm_q};
              imem_we    <= 1'b1;
              rx_ready   <= 1'b0;
              state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          imem_we      <= 1'b0;
          imem_addr    <= imem_addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CHK;
            rx_ready <= 1'b1;
`else
            state     <= S_DONE;
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b0;
            core_hold <= 1'b0;
`endif
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            state    <= S_DONE;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            if (rx_data == csum) begin
              err       <= 1'b0;
              core_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          imem_we  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  a_we_only_in_write : assert property (@(posedge clk) imem_we |-> (state == S_WRITE));
  a_no_ready_in_write : assert property (@(posedge clk) (state == S_WRITE) |-> !rx_ready);

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader; expected writes and flags are hand-computed per frame.
module tb_imem_loader;

  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          core_hold;
  logic [AW:0]   words_loaded;
  logic [2:0]    state_dbg;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .core_hold(core_hold),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] exp_q[$];

  typedef struct {
    logic [95:0] bytes;     // stream order, first byte in [95:88]
    int          nb;
    bit          toggle;
    bit          send_chk;
    logic [7:0]  chk;
    int          n_wr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          err_base;
    bit          err_chk;
    int          words;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard: every write strobe is matched against the expected queue
  always @(negedge clk) begin
    if (imem_we) begin
      check("ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("write_addr", {27'd0, imem_addr}, {27'd0, e[AW+31:32]});
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    rx_data  = b;
    rx_valid = 1'b1;
    cnt = 0;
    while (!rx_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!rx_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {27'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_hold", {31'd0, core_hold}, 32'd1);
    check("rst_words", {26'd0, words_loaded}, 32'd0);
  endtask

  task automatic junk_after_done();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_after_done", {31'd0, rx_ready}, 32'd0);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    bit   exp_err;
    v = vecs[k];
    if (v.n_wr > 0) exp_q.push_back({5'd0, v.w0});
    if (v.n_wr > 1) exp_q.push_back({5'd1, v.w1});
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = v.err_chk;
`else
    exp_err = v.err_base;
`endif
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done_clr", {31'd0, done}, 32'd0);
    check("start_hold", {31'd0, core_hold}, 32'd1);
    for (int i = 0; i < v.nb; i++) begin
      if (v.toggle && i > 0) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(v.bytes[95 - 8*i -: 8]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.send_chk) begin
      if (v.toggle) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(v.chk);
    end
`endif
    rx_valid = 1'b0;
    wait_done();
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("core_hold", {31'd0, core_hold}, {31'd0, exp_err});
    check("words_loaded", {26'd0, words_loaded}, v.words);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("writes_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    junk_after_done();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    vecs[0] = '{bytes: 96'h02_00_13_00_00_00_93_00_10_00_00_00, nb: 10, toggle: 1'b0,
                send_chk: 1'b1, chk: 8'h90, n_wr: 2, w0: 32'h00000013, w1: 32'h00100093,
                err_base: 1'b0, err_chk: 1'b0, words: 2};
    vecs[1] = '{bytes: 96'h02_00_13_00_00_00_93_00_10_00_00_00, nb: 10, toggle: 1'b1,
                send_chk: 1'b1, chk: 8'h90, n_wr: 2, w0: 32'h00000013, w1: 32'h00100093,
                err_base: 1'b0, err_chk: 1'b0, words: 2};
    vecs[2] = '{bytes: 96'h21_00_00_00_00_00_00_00_00_00_00_00, nb: 2, toggle: 1'b0,
                send_chk: 1'b0, chk: 8'h00, n_wr: 0, w0: 32'h0, w1: 32'h0,
                err_base: 1'b1, err_chk: 1'b1, words: 0};
    vecs[3] = '{bytes: 96'h00_00_00_00_00_00_00_00_00_00_00_00, nb: 2, toggle: 1'b0,
                send_chk: 1'b0, chk: 8'h00, n_wr: 0, w0: 32'h0, w1: 32'h0,
                err_base: 1'b0, err_chk: 1'b0, words: 0};
    vecs[4] = '{bytes: 96'h01_00_EF_BE_AD_DE_00_00_00_00_00_00, nb: 6, toggle: 1'b0,
                send_chk: 1'b1, chk: 8'h22, n_wr: 1, w0: 32'hDEADBEEF, w1: 32'h0,
                err_base: 1'b0, err_chk: 1'b0, words: 1};
    vecs[5] = '{bytes: 96'h02_00_13_00_00_00_93_00_10_00_00_00, nb: 10, toggle: 1'b0,
                send_chk: 1'b1, chk: 8'h00, n_wr: 2, w0: 32'h00000013, w1: 32'h00100093,
                err_base: 1'b0, err_chk: 1'b1, words: 2};

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    check("idle_ignores_valid", {31'd0, rx_ready}, 32'd0);
    check("idle_hold", {31'd0, core_hold}, 32'd1);
    rx_valid = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(k);

    // reset right after the 6th byte, while the first word is being written
    exp_q.push_back({5'd0, 32'h00000013});
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(vecs[0].bytes[95 - 8*i -: 8]);
    rx_valid = 1'b0;
    check("we_latency", {31'd0, imem_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("midreset_writes", exp_q.size(), 32'd0);
    exp_q.delete();
    run_vec(4);

    // start pulsed in the middle of DATA must not restart the frame
    exp_q.push_back({5'd0, 32'hDEADBEEF});
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hEF);
    rx_valid = 1'b0;
    pulse_start();
    check("busy_start_ignored", {31'd0, busy}, 32'd1);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    rx_valid = 1'b0;
    wait_done();
    check("busy_seq_words", {26'd0, words_loaded}, 32'd1);
    check("busy_seq_err", {31'd0, err}, 32'd0);
    check("busy_seq_hold", {31'd0, core_hold}, 32'd0);
    check("busy_seq_writes", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
